mips_pc_unit: RTL and testbench

Program-counter and next-address stage of the single-cycle MIPS datapath. It holds the 8-bit word-indexed program counter that drives the instruction memory address. It also selects the next PC from sequential, branch, jump and jump-register sources, and runs a small run/halt state machine with stall support and a retired-instruction counter. The block sits directly upstream of the instruction memory; the control unit and register file feed its redirect inputs.

---
 rtl/mips_pc_unit.sv | 122 ++++++++++++
 tb/tb_mips_pc_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pc_unit.sv
// Program counter and next-address stage of the single-cycle MIPS datapath.
// Optional build macro MIPS_PC_WRAP_TRAP_EN traps a sequential 255->0 wrap into HALTED.
module mips_pc_unit #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [31:0]      rs_value,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  output logic [7:0]       program_counter,
  output logic [7:0]       pc_plus1,
  output logic             fetch_valid,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
`ifdef MIPS_PC_WRAP_TRAP_EN
  ,
  output logic             wrap_fault
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       seq_pc;
  logic             pc_load;
`ifdef MIPS_PC_WRAP_TRAP_EN
  logic             wrap_fault_q, wrap_fault_d;
`endif

  // Only the low address byte of the instruction and rs are meaningful here.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{instruction[31:8], rs_value[31:8]};

  assign seq_pc = pc_q + 8'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    pc_load = 1'b0;
`ifdef MIPS_PC_WRAP_TRAP_EN
    wrap_fault_d = wrap_fault_q;
`endif
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jump_reg) begin
          pc_d    = rs_value[7:0];
          pc_load = 1'b1;
        end else if (jump) begin
          pc_d    = instruction[7:0];
          pc_load = 1'b1;
        end else if (branch_taken) begin
          pc_d    = seq_pc + instruction[7:0];
          pc_load = 1'b1;
        end else begin
`ifdef MIPS_PC_WRAP_TRAP_EN
          if (pc_q == 8'hFF) begin
            state_d      = ST_HALTED;
            wrap_fault_d = 1'b1;
          end else begin
            pc_d    = seq_pc;
            pc_load = 1'b1;
          end
`else
          pc_d    = seq_pc;
          pc_load = 1'b1;
`endif
        end
      end
      ST_HALTED: if (resume) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
    cnt_d = pc_load ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
`ifdef MIPS_PC_WRAP_TRAP_EN
      wrap_fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
`ifdef MIPS_PC_WRAP_TRAP_EN
      wrap_fault_q <= wrap_fault_d;
`endif
    end
  end

  assign program_counter = pc_q;
  assign pc_plus1        = seq_pc;
  assign fetch_valid     = (state_q == ST_RUN);
  assign halted          = (state_q == ST_HALTED);
  assign retired_count   = cnt_q;
`ifdef MIPS_PC_WRAP_TRAP_EN
  assign wrap_fault      = wrap_fault_q;
`endif

endmodule

// File: tb/tb_mips_pc_unit.sv
// Directed self-checking bench for mips_pc_unit; follows the datapath through
// reset, sequential fetch, branch/jump/JR redirects, stall, halt/resume and PC wrap.
module tb_mips_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        branch_taken, jump, jump_reg;
  logic [31:0] rs_value;
  logic        stall, halt_req, resume;
  logic [7:0]  program_counter, pc_plus1;
  logic        fetch_valid, halted;
  logic [15:0] retired_count;
`ifdef MIPS_PC_WRAP_TRAP_EN
  logic        wrap_fault;
`endif

  int checks = 0;
  int errors = 0;

  mips_pc_unit #(.RESET_PC(8'd0), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .instruction     (instruction),
    .branch_taken    (branch_taken),
    .jump            (jump),
    .jump_reg        (jump_reg),
    .rs_value        (rs_value),
    .stall           (stall),
    .halt_req        (halt_req),
    .resume          (resume),
    .program_counter (program_counter),
    .pc_plus1        (pc_plus1),
    .fetch_valid     (fetch_valid),
    .halted          (halted),
    .retired_count   (retired_count)
`ifdef MIPS_PC_WRAP_TRAP_EN
    ,
    .wrap_fault      (wrap_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    instruction  = 32'h0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    jump_reg     = 1'b0;
    rs_value     = 32'h0;
    stall        = 1'b0;
    halt_req     = 1'b0;
    resume       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #13;
    checks++;
    if (program_counter !== 8'h00 || fetch_valid !== 1'b0 || halted !== 1'b0 || retired_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state pc=%h fv=%b halted=%b cnt=%0d expected pc=00 fv=0 halted=0 cnt=0",
               program_counter, fetch_valid, halted, retired_count);
    end
    #4 reset = 1'b0;
    #1;
    checks++;
    if (program_counter !== 8'h00 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_state pc=%h fv=%b expected pc=00 fv=0", program_counter, fetch_valid);
    end
  endtask

  task automatic test_free_run();
    logic [7:0] exp_pc;
    tick();
    checks++;
    if (program_counter !== 8'h00 || fetch_valid !== 1'b1 || retired_count !== 16'd0) begin
      errors++;
      $display("FAIL boot_to_run pc=%h fv=%b cnt=%0d expected pc=00 fv=1 cnt=0",
               program_counter, fetch_valid, retired_count);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_pc = 8'(i);
      checks++;
      if (program_counter !== exp_pc || retired_count !== 16'(i) || pc_plus1 !== exp_pc + 8'd1) begin
        errors++;
        $display("FAIL seq_step%0d pc=%h cnt=%0d plus1=%h expected pc=%h cnt=%0d plus1=%h",
                 i, program_counter, retired_count, pc_plus1, exp_pc, i, exp_pc + 8'd1);
      end
    end
  endtask

  task automatic test_redirects();
    instruction  = 32'h0000_FFFC;
    branch_taken = 1'b1;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h02 || retired_count !== 16'd6) begin
      errors++;
      $display("FAIL branch_back pc=%h cnt=%0d expected pc=02 cnt=6", program_counter, retired_count);
    end
    instruction = 32'h0800_0040;
    jump        = 1'b1;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h40 || retired_count !== 16'd7) begin
      errors++;
      $display("FAIL jump pc=%h cnt=%0d expected pc=40 cnt=7", program_counter, retired_count);
    end
    jump_reg     = 1'b1;
    jump         = 1'b1;
    branch_taken = 1'b1;
    instruction  = 32'h0800_0011;
    rs_value     = 32'h0000_0123;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h23 || retired_count !== 16'd8) begin
      errors++;
      $display("FAIL jr_priority pc=%h cnt=%0d expected pc=23 cnt=8", program_counter, retired_count);
    end
    jump         = 1'b1;
    branch_taken = 1'b1;
    instruction  = 32'h0800_0007;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h07 || retired_count !== 16'd9) begin
      errors++;
      $display("FAIL jump_over_branch pc=%h cnt=%0d expected pc=07 cnt=9", program_counter, retired_count);
    end
  endtask

  task automatic test_stall();
    stall       = 1'b1;
    jump        = 1'b1;
    instruction = 32'h0800_0030;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (program_counter !== 8'h07 || retired_count !== 16'd9 || fetch_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_cycle%0d pc=%h cnt=%0d fv=%b expected pc=07 cnt=9 fv=1",
                 i, program_counter, retired_count, fetch_valid);
      end
    end
    idle();
    tick();
    checks++;
    if (program_counter !== 8'h08 || retired_count !== 16'd10) begin
      errors++;
      $display("FAIL stall_release pc=%h cnt=%0d expected pc=08 cnt=10", program_counter, retired_count);
    end
    tick();
  endtask

  task automatic test_halt_resume();
    halt_req    = 1'b1;
    jump        = 1'b1;
    instruction = 32'h0800_0055;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h09 || halted !== 1'b1 || fetch_valid !== 1'b0 || retired_count !== 16'd11) begin
      errors++;
      $display("FAIL halt_enter pc=%h halted=%b fv=%b cnt=%0d expected pc=09 halted=1 fv=0 cnt=11",
               program_counter, halted, fetch_valid, retired_count);
    end
    jump        = 1'b1;
    jump_reg    = 1'b1;
    rs_value    = 32'h0000_0066;
    instruction = 32'h0800_0055;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h09 || halted !== 1'b1 || retired_count !== 16'd11) begin
      errors++;
      $display("FAIL halt_ignores_jump pc=%h halted=%b cnt=%0d expected pc=09 halted=1 cnt=11",
               program_counter, halted, retired_count);
    end
    resume = 1'b1;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h09 || halted !== 1'b0 || fetch_valid !== 1'b1 || retired_count !== 16'd11) begin
      errors++;
      $display("FAIL resume pc=%h halted=%b fv=%b cnt=%0d expected pc=09 halted=0 fv=1 cnt=11",
               program_counter, halted, fetch_valid, retired_count);
    end
    tick();
    checks++;
    if (program_counter !== 8'h0A || retired_count !== 16'd12) begin
      errors++;
      $display("FAIL after_resume pc=%h cnt=%0d expected pc=0a cnt=12", program_counter, retired_count);
    end
  endtask

  task automatic test_branch_forward();
    instruction  = 32'h1000_0005;
    branch_taken = 1'b1;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'h10 || retired_count !== 16'd13) begin
      errors++;
      $display("FAIL branch_fwd pc=%h cnt=%0d expected pc=10 cnt=13", program_counter, retired_count);
    end
  endtask

  task automatic test_wrap();
    instruction = 32'h0800_00FF;
    jump        = 1'b1;
    tick();
    idle();
    checks++;
    if (program_counter !== 8'hFF || pc_plus1 !== 8'h00 || retired_count !== 16'd14) begin
      errors++;
      $display("FAIL jump_ff pc=%h plus1=%h cnt=%0d expected pc=ff plus1=00 cnt=14",
               program_counter, pc_plus1, retired_count);
    end
    tick();
`ifdef MIPS_PC_WRAP_TRAP_EN
    checks++;
    if (program_counter !== 8'hFF || halted !== 1'b1 || wrap_fault !== 1'b1 || retired_count !== 16'd14) begin
      errors++;
      $display("FAIL wrap_trap pc=%h halted=%b wf=%b cnt=%0d expected pc=ff halted=1 wf=1 cnt=14",
               program_counter, halted, wrap_fault, retired_count);
    end
`else
    checks++;
    if (program_counter !== 8'h00 || halted !== 1'b0 || retired_count !== 16'd15) begin
      errors++;
      $display("FAIL wrap_seq pc=%h halted=%b cnt=%0d expected pc=00 halted=0 cnt=15",
               program_counter, halted, retired_count);
    end
`endif
    #2 reset = 1'b1;
    #1;
    checks++;
    if (program_counter !== 8'h00 || halted !== 1'b0 || fetch_valid !== 1'b0 || retired_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset pc=%h halted=%b fv=%b cnt=%0d expected pc=00 halted=0 fv=0 cnt=0",
               program_counter, halted, fetch_valid, retired_count);
    end
`ifdef MIPS_PC_WRAP_TRAP_EN
    checks++;
    if (wrap_fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_wf wf=%b expected 0", wrap_fault);
    end
`endif
    #3 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_redirects();
    test_stall();
    test_halt_resume();
    test_branch_forward();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
